ir_remote_control_rx: RTL and testbench

- Synthesizable IR remote-control receiver; the receive-side counterpart of the IR transmit bench model.
- Takes the carrier-modulated IR line and recovers the envelope (mark = carrier or steady high, space = low).
- Decodes one frame, LSB first, in one of three codings: bi-phase, pulse-distance or pulse-length.
- Presents the decoded word with a one-cycle valid strobe to the host logic.

---
 rtl/ir_remote_control_rx.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_ir_remote_control_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_remote_control_rx.sv
// ---------------------------------------------------------------------------
// ir_remote_control_rx
//
// IR remote-control receiver. The raw, carrier-modulated IR line is
// synchronised, turned into an envelope (mark = carrier present, space =
// quiet), and one frame is decoded LSB first in bi-phase, pulse-distance or
// pulse-length coding. The decoded word is presented with a one-cycle strobe.
//
// Ports
//   i_clk       system clock
//   i_rst       synchronous active-high reset
//   i_ir_din    raw IR line (asynchronous)
//   i_mode_sel  0 = bi-phase, 1 = pulse-distance, 2 = pulse-length, 3 = reserved
//   i_bit_cnt   bits per frame, 1..32 (larger values clamp to 32)
//   o_data      decoded word, bit n = n-th received bit, unreceived bits 0
//   o_valid     one-cycle pulse, o_data holds a new word
//   o_err       one-cycle pulse, frame aborted
//   o_busy      high from frame start until the block is idle again
//   o_env       recovered envelope
// ---------------------------------------------------------------------------
module ir_remote_control_rx #(
   parameter int P_ENV_HOLD = 48,
   parameter int P_UNIT     = 1067,
   parameter int P_IDLE     = 4268,
   parameter int P_CW       = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ir_din,
   input  logic [1:0]  i_mode_sel,
   input  logic [5:0]  i_bit_cnt,
   output logic [31:0] o_data,
   output logic        o_valid,
   output logic        o_err,
   output logic        o_busy,
   output logic        o_env
);

   typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE, S_WAIT_IDLE} state_t;

   localparam logic [1:0]      M_DIST    = 2'd1;
   localparam logic [1:0]      M_LEN     = 2'd2;
   localparam logic [P_CW-1:0] HOLD_LAST = P_CW'(P_ENV_HOLD - 1);
   localparam logic [P_CW-1:0] T_HALF    = P_CW'(P_UNIT / 2);
   localparam logic [P_CW-1:0] T_3H      = P_CW'((3 * P_UNIT) / 2);
   localparam logic [P_CW-1:0] T_5H      = P_CW'((5 * P_UNIT) / 2);
   localparam logic [P_CW-1:0] IDLE_LEN  = P_CW'(P_IDLE);
   localparam logic [P_CW-1:0] DUR_MAX   = '1;

   logic            sync1_q, sync2_q;
   logic            env_q, env_d, env_dly_q;
   logic [P_CW-1:0] low_cnt_q, low_cnt_d;
   logic [P_CW-1:0] dur_q, dur_d;
   state_t          state_q, state_d;
   logic [1:0]      mode_q, mode_d;
   logic [5:0]      cnt_q, cnt_d, idx_q, idx_d, cnt_sel;
   logic [31:0]     shift_q, shift_d, data_q, data_d;
   logic            mid_q, mid_d;   // bi-phase: currently at a mid-bit point
   logic            one_q, one_d;   // pulse-distance: this space already gave a 1
   logic            valid_q, valid_d, err_q, err_d;
   logic            rise, fall, is_1t, is_2t;
   logic            bit_en, bit_val, abort;

   assign rise    = env_q & ~env_dly_q;
   assign fall    = ~env_q & env_dly_q;
   assign is_1t   = (dur_q >= T_HALF) && (dur_q < T_3H);
   assign is_2t   = (dur_q >= T_3H) && (dur_q < T_5H);
   assign cnt_sel = (i_bit_cnt > 6'd32) ? 6'd32 : i_bit_cnt;

   // Envelope: any synchronised high sets it; it only drops after a low run
   // longer than the carrier low phase. dur restarts on every envelope edge,
   // so on an edge cycle it still holds the length of the interval that ended.
   always_comb begin
      env_d     = env_q;
      low_cnt_d = low_cnt_q;
      if (sync2_q) begin
         env_d     = 1'b1;
         low_cnt_d = '0;
      end else if (env_q) begin
         if (low_cnt_q == HOLD_LAST) begin
            env_d     = 1'b0;
            low_cnt_d = '0;
         end else begin
            low_cnt_d = low_cnt_q + 1'b1;
         end
      end
      if (env_q != env_dly_q)
         dur_d = P_CW'(1);
      else if (dur_q == DUR_MAX)
         dur_d = dur_q;
      else
         dur_d = dur_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      mid_d   = mid_q;
      one_d   = one_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      bit_en  = 1'b0;
      bit_val = 1'b0;
      abort   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rise) begin
               mode_d = i_mode_sel;
               cnt_d  = cnt_sel;
               if (cnt_sel == 6'd0 || i_mode_sel == 2'd3) begin
                  abort = 1'b1;
               end else begin
                  shift_d = '0;
                  idx_d   = '0;
                  mid_d   = 1'b0;   // frame starts on a bit boundary
                  one_d   = 1'b0;
                  state_d = S_MARK;
               end
            end
         end
         S_MARK: begin
            if (fall) begin
               state_d = S_SPACE;
               one_d   = 1'b0;
               case (mode_q)
                  M_LEN: begin
                     if (is_1t) begin
                        bit_en = 1'b1;
                     end else if (is_2t) begin
                        bit_en  = 1'b1;
                        bit_val = 1'b1;
                     end else begin
                        abort = 1'b1;
                     end
                  end
                  M_DIST: abort = !is_1t;
                  default: begin
                     // Falling edge at mid-bit decides a 0.
                     if (!mid_q) begin
                        if (is_1t) begin
                           bit_en = 1'b1;
                           mid_d  = 1'b1;
                        end else begin
                           abort = 1'b1;
                        end
                     end else if (is_1t) begin
                        mid_d = 1'b0;
                     end else if (is_2t) begin
                        bit_en = 1'b1;
                     end else begin
                        abort = 1'b1;
                     end
                  end
               endcase
            end else if (dur_q >= T_5H) begin
               abort = 1'b1;
            end
         end
         S_SPACE: begin
            if (rise) begin
               state_d = S_MARK;
               case (mode_q)
                  M_LEN: abort = !is_1t;
                  M_DIST: begin
                     if (!one_q) begin
                        if (is_1t) begin
                           bit_en = 1'b1;
                        end else if (is_2t) begin
                           bit_en  = 1'b1;
                           bit_val = 1'b1;
                        end else begin
                           abort = 1'b1;
                        end
                     end
                  end
                  default: begin
                     // Rising edge at mid-bit decides a 1.
                     if (!mid_q) begin
                        if (is_1t) begin
                           bit_en  = 1'b1;
                           bit_val = 1'b1;
                           mid_d   = 1'b1;
                        end else begin
                           abort = 1'b1;
                        end
                     end else if (is_1t) begin
                        mid_d = 1'b0;
                     end else if (is_2t) begin
                        bit_en  = 1'b1;
                        bit_val = 1'b1;
                     end else begin
                        abort = 1'b1;
                     end
                  end
               endcase
            end else begin
               // A long space is a 1 as soon as it passes 3T/2, so the last
               // bit of a frame needs no closing mark.
               if (mode_q == M_DIST && !one_q && dur_q >= T_3H) begin
                  bit_en  = 1'b1;
                  bit_val = 1'b1;
                  one_d   = 1'b1;
               end
               if ((mode_q == M_LEN) ? (dur_q >= T_3H) : (dur_q >= T_5H))
                  abort = 1'b1;
            end
         end
         S_WAIT_IDLE: begin
            if (!env_q && !env_dly_q && dur_q >= IDLE_LEN)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (bit_en) begin
         shift_d[idx_q[4:0]] = bit_val;
         idx_d = idx_q + 6'd1;
         if (idx_d == cnt_q) begin
            data_d  = shift_d;
            valid_d = 1'b1;
            state_d = S_WAIT_IDLE;
         end
      end
      // An error always wins over a completion in the same cycle.
      if (abort) begin
         err_d   = 1'b1;
         valid_d = 1'b0;
         data_d  = data_q;
         state_d = S_WAIT_IDLE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         env_q     <= 1'b0;
         env_dly_q <= 1'b0;
         low_cnt_q <= '0;
         dur_q     <= '0;
         state_q   <= S_IDLE;
         mode_q    <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         mid_q     <= 1'b0;
         one_q     <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         sync1_q   <= i_ir_din;
         sync2_q   <= sync1_q;
         env_q     <= env_d;
         env_dly_q <= env_q;
         low_cnt_q <= low_cnt_d;
         dur_q     <= dur_d;
         state_q   <= state_d;
         mode_q    <= mode_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         mid_q     <= mid_d;
         one_q     <= one_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_err   = err_q;
   assign o_busy  = (state_q != S_IDLE);
   assign o_env   = env_q;

endmodule

// File: tb/tb_ir_remote_control_rx.sv
// ---------------------------------------------------------------------------
// tb_ir_remote_control_rx
//
// Directed bench for ir_remote_control_rx. Instance A runs a 30 kHz carrier
// with a unit of 8 carrier periods (P_UNIT 267); instance B runs a 56 kHz
// carrier with a unit of 32 carrier periods (P_UNIT 571). Frames are built
// from the reference data words and the decoded words are compared against
// those words.
// ---------------------------------------------------------------------------
module tb_ir_remote_control_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_line;
   logic        tx_sel;      // 0 = drive instance A, 1 = drive instance B
   logic        din_a, din_b;
   logic [1:0]  mode;
   logic [5:0]  nbits;
   logic [31:0] data_a, data_b;
   logic        valid_a, err_a, busy_a, env_a;
   logic        valid_b, err_b, busy_b, env_b;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int va_n = 0, ea_n = 0, vb_n = 0, eb_n = 0;
   int err_cyc_a = 0;
   int hi_c = 16, lo_c = 17, ppu = 8;

   always #5 clk = ~clk;

   assign din_a = tx_sel ? 1'b0 : tx_line;
   assign din_b = tx_sel ? tx_line : 1'b0;

   ir_remote_control_rx #(.P_ENV_HOLD(48), .P_UNIT(267), .P_IDLE(1068), .P_CW(16)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_ir_din(din_a), .i_mode_sel(mode), .i_bit_cnt(nbits),
      .o_data(data_a), .o_valid(valid_a), .o_err(err_a), .o_busy(busy_a), .o_env(env_a));

   ir_remote_control_rx #(.P_ENV_HOLD(48), .P_UNIT(571), .P_IDLE(2284), .P_CW(16)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_ir_din(din_b), .i_mode_sel(mode), .i_bit_cnt(nbits),
      .o_data(data_b), .o_valid(valid_b), .o_err(err_b), .o_busy(busy_b), .o_env(env_b));

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: counts cycles each strobe is high.
   always @(negedge clk) begin
      if (valid_a) va_n <= va_n + 1;
      if (err_a) begin
         ea_n      <= ea_n + 1;
         err_cyc_a <= cyc;
      end
      if (valid_b) vb_n <= vb_n + 1;
      if (err_b) eb_n <= eb_n + 1;
   end

   task automatic use_a();
      tx_sel = 1'b0; hi_c = 16; lo_c = 17; ppu = 8;
   endtask

   task automatic use_b();
      tx_sel = 1'b1; hi_c = 9; lo_c = 9; ppu = 32;
   endtask

   task automatic send_mark(input int units);
      for (int p = 0; p < units * ppu; p++) begin
         tx_line = 1'b1;
         repeat (hi_c) @(negedge clk);
         tx_line = 1'b0;
         repeat (lo_c) @(negedge clk);
      end
   endtask

   task automatic send_space(input int units);
      tx_line = 1'b0;
      repeat (units * ppu * (hi_c + lo_c)) @(negedge clk);
   endtask

   task automatic send_biphase(input logic [31:0] d, input int n);
      logic lvl, run_lvl;
      int   run_len;
      run_lvl = 1'b1;
      run_len = 0;
      for (int b = 0; b < n; b++) begin
         for (int h = 0; h < 2; h++) begin
            lvl = d[b] ? (h == 1) : (h == 0);
            if (run_len > 0 && lvl != run_lvl) begin
               if (run_lvl) send_mark(run_len); else send_space(run_len);
               run_len = 0;
            end
            run_lvl = lvl;
            run_len++;
         end
      end
      if (run_lvl) send_mark(run_len); else send_space(run_len);
   endtask

   task automatic send_distance(input logic [31:0] d, input int n, input bit trail);
      for (int b = 0; b < n; b++) begin
         send_mark(1);
         send_space(d[b] ? 2 : 1);
      end
      if (trail && !d[n-1]) send_mark(1);
   endtask

   task automatic send_length(input logic [31:0] d, input int n);
      for (int b = 0; b < n; b++) begin
         send_mark(d[b] ? 2 : 1);
         if (b < n - 1) send_space(1);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((tx_sel ? busy_b : busy_a) && n < 12000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (tx_sel ? busy_b : busy_a) begin
         failures++;
         $display("FAIL %s_idle_timeout busy still 1 after %0d cycles, want 0", tag, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; tx_line = 1'b0; mode = 2'd0; nbits = 6'd14;
      use_a();
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (data_a !== 32'h0) begin failures++; $display("FAIL rst_data_a got=%h want=0", data_a); end
      checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL rst_valid_a got=%b want=0", valid_a); end
      checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL rst_err_a got=%b want=0", err_a); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rst_busy_a got=%b want=0", busy_a); end
      checks++; if (env_a !== 1'b0) begin failures++; $display("FAIL rst_env_a got=%b want=0", env_a); end
      checks++; if (data_b !== 32'h0 || busy_b !== 1'b0) begin
         failures++; $display("FAIL rst_b got data=%h busy=%b want data=0 busy=0", data_b, busy_b);
      end
      $display("reset: outputs checked");
   endtask

   task automatic test_biphase();
      int v0, e0;
      use_a(); mode = 2'd0; nbits = 6'd14;
      v0 = va_n; e0 = ea_n;
      send_biphase(32'h0A04, 14);
      wait_idle("biphase");
      checks++; if (va_n - v0 != 1) begin failures++; $display("FAIL biphase_valid got=%0d pulses want=1", va_n - v0); end
      checks++; if (data_a !== 32'h00000A04) begin failures++; $display("FAIL biphase_data got=%h want=00000a04", data_a); end
      checks++; if (ea_n != e0) begin failures++; $display("FAIL biphase_err got=%0d pulses want=0", ea_n - e0); end
      $display("biphase frame: data=%h", data_a);
   endtask

   task automatic test_distance();
      int v0, e0;
      use_a(); mode = 2'd1; nbits = 6'd14;
      v0 = va_n; e0 = ea_n;
      send_distance(32'h3F04, 14, 1'b1);
      // Last bit is a 1 and no closing mark follows: it must already be out.
      checks++; if (va_n - v0 != 1) begin failures++; $display("FAIL distance_valid_early got=%0d pulses want=1", va_n - v0); end
      wait_idle("distance");
      checks++; if (data_a !== 32'h00003F04) begin failures++; $display("FAIL distance_data got=%h want=00003f04", data_a); end
      checks++; if (ea_n != e0 || va_n - v0 != 1) begin
         failures++; $display("FAIL distance_pulses got err=%0d valid=%0d want err=0 valid=1", ea_n - e0, va_n - v0);
      end
      $display("distance frame: data=%h", data_a);
   endtask

   task automatic test_length();
      int v0, e0;
      use_b(); mode = 2'd2; nbits = 6'd14;
      v0 = vb_n; e0 = eb_n;
      send_length(32'h1504, 14);
      wait_idle("length");
      checks++; if (vb_n - v0 != 1) begin failures++; $display("FAIL length_valid got=%0d pulses want=1", vb_n - v0); end
      checks++; if (data_b !== 32'h00001504) begin failures++; $display("FAIL length_data got=%h want=00001504", data_b); end
      checks++; if (eb_n != e0) begin failures++; $display("FAIL length_err got=%0d pulses want=0", eb_n - e0); end
      $display("length frame: data=%h", data_b);
   endtask

   task automatic test_length_error();
      int v0, e0;
      use_b(); mode = 2'd2; nbits = 6'd14;
      v0 = vb_n; e0 = eb_n;
      send_length(32'h4, 3);
      send_space(1);
      send_mark(3);
      // Line is quiet from here on.
      repeat (2284 - 100) @(negedge clk);
      checks++; if (busy_b !== 1'b1) begin failures++; $display("FAIL lenerr_busy_early got=%b want=1", busy_b); end
      repeat (300) @(negedge clk);
      checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL lenerr_busy_late got=%b want=0", busy_b); end
      checks++; if (eb_n - e0 != 1) begin failures++; $display("FAIL lenerr_err got=%0d pulses want=1", eb_n - e0); end
      checks++; if (vb_n != v0) begin failures++; $display("FAIL lenerr_valid got=%0d pulses want=0", vb_n - v0); end
      $display("length frame with 3T mark: err pulses=%0d", eb_n - e0);
   endtask

   task automatic test_mid_reset();
      int v0, e0;
      use_a(); mode = 2'd1; nbits = 6'd14;
      v0 = va_n; e0 = ea_n;
      send_distance(32'h3F04, 6, 1'b0);
      send_mark(1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (data_a !== 32'h0 || busy_a !== 1'b0 || env_a !== 1'b0) begin
         failures++; $display("FAIL midrst_outputs got data=%h busy=%b env=%b want 0 0 0", data_a, busy_a, env_a);
      end
      repeat (1500) @(negedge clk);
      checks++; if (va_n != v0 || ea_n != e0) begin
         failures++; $display("FAIL midrst_pulses got valid=%0d err=%0d want 0 0", va_n - v0, ea_n - e0);
      end
      nbits = 6'd4;
      send_distance(32'h5, 4, 1'b1);
      wait_idle("midrst");
      checks++; if (data_a !== 32'h00000005 || va_n - v0 != 1) begin
         failures++; $display("FAIL midrst_next_frame got data=%h valid=%0d want 00000005 1", data_a, va_n - v0);
      end
      $display("reset mid-frame then clean frame: data=%h", data_a);
   endtask

   task automatic test_bad_config();
      int v0, e0, c0;
      use_a(); mode = 2'd3; nbits = 6'd14;
      v0 = va_n; e0 = ea_n;
      c0 = cyc;
      send_mark(1);
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL mode3_busy got=%b want=1", busy_a); end
      wait_idle("mode3");
      checks++; if (ea_n - e0 != 1) begin failures++; $display("FAIL mode3_err got=%0d pulses want=1", ea_n - e0); end
      // line high -> 2 sync flops -> envelope -> frame start -> o_err
      checks++; if (err_cyc_a - c0 != 4) begin failures++; $display("FAIL mode3_err_latency got=%0d want=4", err_cyc_a - c0); end
      mode = 2'd0; nbits = 6'd0;
      e0 = ea_n;
      send_mark(1);
      wait_idle("zerobits");
      checks++; if (ea_n - e0 != 1) begin failures++; $display("FAIL zerobits_err got=%0d pulses want=1", ea_n - e0); end
      checks++; if (va_n != v0) begin failures++; $display("FAIL badcfg_valid got=%0d pulses want=0", va_n - v0); end
      $display("reserved mode and zero bit count: err pulses checked");
   endtask

   initial begin
      test_reset();
      test_biphase();
      test_distance();
      test_length();
      test_length_error();
      test_mid_reset();
      test_bad_config();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
